// File: rtl/io_tape_device.sv
// io_tape_device: tape reader / punch emulator bridging host streams to the I/O unit handshakes
module io_tape_device #(
    parameter int DEPTH = 8,
    parameter int GAP   = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     host_in_valid,
    output logic                     host_in_ready,
    input  logic [4:0]               host_in_data,
    output logic                     host_out_valid,
    input  logic                     host_out_ready,
    output logic [4:0]               host_out_data,
    input  logic                     flush,
    input  logic                     input_rdy_from_io,
    output logic                     input_val_to_io,
    output logic [4:0]               input_data_to_io,
    input  logic                     output_rdy_from_io,
    output logic                     output_ack_to_io,
    input  logic [4:0]               output_data_from_io,
    output logic [$clog2(DEPTH):0]   in_level,
    output logic [$clog2(DEPTH):0]   out_level,
    output logic [15:0]              in_chars,
    output logic [15:0]              out_chars
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int GW = GAP > 0 ? $clog2(GAP + 1) : 1;

    typedef enum logic {R_WAIT, R_VAL} r_state_t;
    typedef enum logic {P_WAIT, P_ACK} p_state_t;

    r_state_t r_state, r_next;
    p_state_t p_state, p_next;
    logic [4:0]    in_mem [DEPTH];
    logic [4:0]    out_mem[DEPTH];
    logic [AW-1:0] in_wr, in_rd, out_wr, out_rd;
    logic [GW-1:0] gap_in, gap_out;
    logic [4:0]    hold;
    logic          in_full, in_empty, out_full, out_empty;
    logic          in_push, in_pop, in_done, out_push, out_pop, out_done;

    assign in_full          = in_level == LW'(DEPTH);
    assign in_empty         = in_level == '0;
    assign out_full         = out_level == LW'(DEPTH);
    assign out_empty        = out_level == '0;
    assign host_in_ready    = !in_full;
    assign host_out_valid   = !out_empty;
    assign host_out_data    = out_empty ? 5'd0 : out_mem[out_rd];
    assign in_push          = host_in_valid && !in_full;
    assign out_pop          = host_out_valid && host_out_ready;
    assign input_val_to_io  = r_state == R_VAL;
    assign input_data_to_io = hold;
    assign output_ack_to_io = p_state == P_ACK;

    // FIFO storage; stale writes during flush are harmless because pointers reset
    always_ff @(posedge clk) begin
        if (in_push) in_mem[in_wr] <= host_in_data;
        if (out_push) out_mem[out_wr] <= output_data_from_io;
    end

    // FIFO pointers and occupancy; flush wins over same-cycle push/pop
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            in_wr     <= '0;
            in_rd     <= '0;
            in_level  <= '0;
            out_wr    <= '0;
            out_rd    <= '0;
            out_level <= '0;
        end else if (flush) begin
            in_wr     <= '0;
            in_rd     <= '0;
            in_level  <= '0;
            out_wr    <= '0;
            out_rd    <= '0;
            out_level <= '0;
        end else begin
            in_wr     <= in_wr + AW'(in_push);
            in_rd     <= in_rd + AW'(in_pop);
            in_level  <= in_level + LW'(in_push) - LW'(in_pop);
            out_wr    <= out_wr + AW'(out_push);
            out_rd    <= out_rd + AW'(out_pop);
            out_level <= out_level + LW'(out_push) - LW'(out_pop);
        end
    end

    // Reader and punch next-state: rise only on sampled rdy, fall when rdy drops
    always_comb begin
        r_next   = r_state;
        p_next   = p_state;
        in_pop   = 1'b0;
        in_done  = 1'b0;
        out_push = 1'b0;
        out_done = 1'b0;
        if (r_state == R_WAIT) begin
            in_pop = input_rdy_from_io && !in_empty && gap_in == '0;
            r_next = in_pop ? R_VAL : R_WAIT;
        end else begin
            in_done = !input_rdy_from_io;
            r_next  = in_done ? R_WAIT : R_VAL;
        end
        if (p_state == P_WAIT) begin
            out_push = output_rdy_from_io && !out_full && gap_out == '0;
            p_next   = out_push ? P_ACK : P_WAIT;
        end else begin
            out_done = !output_rdy_from_io;
            p_next   = out_done ? P_WAIT : P_ACK;
        end
    end

    // Handshake state, hold register, inter-character gaps and character counters
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= R_WAIT;
            p_state   <= P_WAIT;
            hold      <= '0;
            gap_in    <= '0;
            gap_out   <= '0;
            in_chars  <= '0;
            out_chars <= '0;
        end else begin
            r_state   <= r_next;
            p_state   <= p_next;
            hold      <= in_pop ? in_mem[in_rd] : hold;
            gap_in    <= in_done ? GW'(GAP) : gap_in - GW'(gap_in != '0);
            gap_out   <= out_done ? GW'(GAP) : gap_out - GW'(gap_out != '0);
            in_chars  <= in_chars + 16'(in_done);
            out_chars <= out_chars + 16'(out_done);
        end
    end
endmodule

// File: tb/tb_io_tape_device.sv
// tb_io_tape_device: directed scenarios plus randomized run against a queue-based reference model
module tb_io_tape_device;
    localparam int DEPTH = 8;
    localparam int GAP   = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 0;
    logic          resetn = 0;
    logic          host_in_valid = 0, host_in_ready;
    logic [4:0]    host_in_data = 0;
    logic          host_out_valid, host_out_ready = 0;
    logic [4:0]    host_out_data;
    logic          flush = 0;
    logic          input_rdy_from_io = 0, input_val_to_io;
    logic [4:0]    input_data_to_io;
    logic          output_rdy_from_io = 0, output_ack_to_io;
    logic [4:0]    output_data_from_io = 0;
    logic [LW-1:0] in_level, out_level;
    logic [15:0]   in_chars, out_chars;
    int            errors = 0, checks = 0;

    io_tape_device #(.DEPTH(DEPTH), .GAP(GAP)) dut (
        .clk(clk), .resetn(resetn),
        .host_in_valid(host_in_valid), .host_in_ready(host_in_ready), .host_in_data(host_in_data),
        .host_out_valid(host_out_valid), .host_out_ready(host_out_ready), .host_out_data(host_out_data),
        .flush(flush),
        .input_rdy_from_io(input_rdy_from_io), .input_val_to_io(input_val_to_io), .input_data_to_io(input_data_to_io),
        .output_rdy_from_io(output_rdy_from_io), .output_ack_to_io(output_ack_to_io), .output_data_from_io(output_data_from_io),
        .in_level(in_level), .out_level(out_level), .in_chars(in_chars), .out_chars(out_chars)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic do_reset();
        @(negedge clk);
        resetn = 0;
        host_in_valid = 0; host_out_ready = 0; flush = 0;
        input_rdy_from_io = 0; output_rdy_from_io = 0;
        host_in_data = 0; output_data_from_io = 0;
        repeat (2) @(negedge clk);
        resetn = 1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({input_val_to_io, output_ack_to_io, input_data_to_io, host_in_ready, host_out_valid, host_out_data, in_level, out_level, in_chars, out_chars}
            !== {1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0, LW'(0), LW'(0), 16'd0, 16'd0}) begin
            errors++;
            $display("FAIL reset_state: val=%b ack=%b data=%h rdy=%b ovalid=%b odata=%h lvl=%0d/%0d chars=%0d/%0d",
                     input_val_to_io, output_ack_to_io, input_data_to_io, host_in_ready, host_out_valid, host_out_data,
                     in_level, out_level, in_chars, out_chars);
        end
        host_in_valid = 1; host_in_data = 5'b00111; input_rdy_from_io = 1;
        @(negedge clk);
        host_in_valid = 0;
        @(negedge clk);
        checks++;
        if (input_val_to_io !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre_val: got val=%b want 1", input_val_to_io);
        end
        #2 resetn = 0;
        #1;
        checks++;
        if ({input_val_to_io, in_level, host_in_ready, in_chars} !== {1'b0, LW'(0), 1'b1, 16'd0}) begin
            errors++;
            $display("FAIL reset_async: val=%b lvl=%0d rdy=%b chars=%0d want 0 0 1 0",
                     input_val_to_io, in_level, host_in_ready, in_chars);
        end
        @(negedge clk);
        input_rdy_from_io = 0;
        resetn = 1;
    endtask

    task automatic test_single_read();
        do_reset();
        host_in_valid = 1; host_in_data = 5'b10011; input_rdy_from_io = 1;
        @(negedge clk);
        host_in_valid = 0;
        checks++;
        if ({input_val_to_io, in_level} !== {1'b0, LW'(1)}) begin
            errors++;
            $display("FAIL read_after_push: val=%b lvl=%0d want 0 1", input_val_to_io, in_level);
        end
        @(negedge clk);
        checks++;
        if ({input_val_to_io, input_data_to_io, in_level} !== {1'b1, 5'b10011, LW'(0)}) begin
            errors++;
            $display("FAIL read_val: val=%b data=%b lvl=%0d want 1 10011 0", input_val_to_io, input_data_to_io, in_level);
        end
        input_rdy_from_io = 0;
        @(negedge clk);
        checks++;
        if ({input_val_to_io, in_chars, input_data_to_io} !== {1'b0, 16'd1, 5'b10011}) begin
            errors++;
            $display("FAIL read_fall: val=%b chars=%0d hold=%b want 0 1 10011", input_val_to_io, in_chars, input_data_to_io);
        end
    endtask

    task automatic test_gap();
        int rise;
        rise = -1;
        do_reset();
        host_in_valid = 1; host_in_data = 5'b10001; input_rdy_from_io = 1;
        @(negedge clk);
        host_in_data = 5'b10010;
        @(negedge clk);
        host_in_valid = 0;
        input_rdy_from_io = 0;
        checks++;
        if ({input_val_to_io, input_data_to_io} !== {1'b1, 5'b10001}) begin
            errors++;
            $display("FAIL gap_first: val=%b data=%b want 1 10001", input_val_to_io, input_data_to_io);
        end
        @(negedge clk);
        for (int k = 1; k <= 12 && rise < 0; k++) begin
            if (k == 4) input_rdy_from_io = 1;
            @(negedge clk);
            if (input_val_to_io) rise = k;
        end
        checks++;
        if (rise !== GAP + 1 || input_data_to_io !== 5'b10010) begin
            errors++;
            $display("FAIL gap_timing: rise after %0d cycles data=%b want %0d 10010", rise, input_data_to_io, GAP + 1);
        end
        input_rdy_from_io = 0;
        @(negedge clk);
    endtask

    task automatic test_punch_backpressure();
        int acks;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            output_data_from_io = 5'(8'h10 + i);
            output_rdy_from_io = 1;
            for (int k = 0; k < 20 && !output_ack_to_io; k++) @(negedge clk);
            checks++;
            if (output_ack_to_io !== 1'b1) begin
                errors++;
                $display("FAIL punch_ack_%0d: got ack=%b want 1", i, output_ack_to_io);
            end
            output_rdy_from_io = 0;
            for (int k = 0; k < 5 && output_ack_to_io; k++) @(negedge clk);
        end
        output_data_from_io = 5'h18;
        output_rdy_from_io = 1;
        acks = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            acks += int'(output_ack_to_io);
        end
        checks++;
        if ({acks, out_level, host_out_valid, host_out_data} !== {32'd0, LW'(8), 1'b1, 5'h10}) begin
            errors++;
            $display("FAIL punch_full: acks=%0d lvl=%0d valid=%b head=%h want 0 8 1 10", acks, out_level, host_out_valid, host_out_data);
        end
        host_out_ready = 1;
        @(negedge clk);
        host_out_ready = 0;
        for (int k = 0; k < 2 && !output_ack_to_io; k++) @(negedge clk);
        checks++;
        if (output_ack_to_io !== 1'b1) begin
            errors++;
            $display("FAIL punch_release: ack=%b want 1 after pop", output_ack_to_io);
        end
        output_rdy_from_io = 0;
        @(negedge clk);
        checks++;
        if ({output_ack_to_io, out_chars, out_level} !== {1'b0, 16'd9, LW'(8)}) begin
            errors++;
            $display("FAIL punch_count: ack=%b chars=%0d lvl=%0d want 0 9 8", output_ack_to_io, out_chars, out_level);
        end
        host_out_ready = 1;
        for (int i = 1; i <= 8; i++) begin
            checks++;
            if ({host_out_valid, host_out_data} !== {1'b1, 5'(8'h10 + i)}) begin
                errors++;
                $display("FAIL drain_%0d: valid=%b data=%h want 1 %h", i, host_out_valid, host_out_data, 5'(8'h10 + i));
            end
            @(negedge clk);
        end
        host_out_ready = 0;
        checks++;
        if ({host_out_valid, host_out_data, out_level} !== {1'b0, 5'd0, LW'(0)}) begin
            errors++;
            $display("FAIL drain_empty: valid=%b data=%h lvl=%0d want 0 00 0", host_out_valid, host_out_data, out_level);
        end
    endtask

    task automatic test_input_full();
        do_reset();
        for (int i = 0; i < 9; i++) begin
            host_in_valid = 1; host_in_data = 5'(i + 3);
            @(negedge clk);
            if (i == 7) begin
                checks++;
                if ({host_in_ready, in_level} !== {1'b0, LW'(8)}) begin
                    errors++;
                    $display("FAIL full_at_8: ready=%b lvl=%0d want 0 8", host_in_ready, in_level);
                end
            end
        end
        host_in_valid = 0;
        checks++;
        if ({host_in_ready, in_level} !== {1'b0, LW'(8)}) begin
            errors++;
            $display("FAIL full_9th: ready=%b lvl=%0d want 0 8", host_in_ready, in_level);
        end
    endtask

    task automatic test_flush();
        int extra;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            host_in_valid = 1; host_in_data = i == 0 ? 5'b10101 : 5'(i);
            @(negedge clk);
        end
        host_in_valid = 0;
        input_rdy_from_io = 1;
        @(negedge clk);
        checks++;
        if ({input_val_to_io, input_data_to_io, in_level} !== {1'b1, 5'b10101, LW'(3)}) begin
            errors++;
            $display("FAIL flush_setup: val=%b data=%b lvl=%0d want 1 10101 3", input_val_to_io, input_data_to_io, in_level);
        end
        flush = 1;
        @(negedge clk);
        flush = 0;
        checks++;
        if ({input_val_to_io, input_data_to_io, in_level} !== {1'b1, 5'b10101, LW'(0)}) begin
            errors++;
            $display("FAIL flush_clear: val=%b data=%b lvl=%0d want 1 10101 0", input_val_to_io, input_data_to_io, in_level);
        end
        input_rdy_from_io = 0;
        @(negedge clk);
        checks++;
        if ({input_val_to_io, in_chars} !== {1'b0, 16'd1}) begin
            errors++;
            $display("FAIL flush_complete: val=%b chars=%0d want 0 1", input_val_to_io, in_chars);
        end
        input_rdy_from_io = 1;
        extra = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            extra += int'(input_val_to_io);
        end
        input_rdy_from_io = 0;
        checks++;
        if (extra !== 0) begin
            errors++;
            $display("FAIL flush_no_more: val high %0d cycles want 0", extra);
        end
    endtask

    task automatic test_random();
        logic [4:0]  in_q[$];
        logic [4:0]  out_q[$];
        logic        m_val, m_ack;
        logic [4:0]  m_hold, head;
        logic [15:0] m_ic, m_oc;
        logic [53:0] exp_v, act_v;
        int          in_fall, out_fall, in_sz, out_sz;
        m_val = 0; m_ack = 0; m_hold = 0; m_ic = 0; m_oc = 0;
        in_fall = -100; out_fall = -100;
        do_reset();
        for (int c = 1; c <= 800; c++) begin
            host_in_valid = $urandom_range(9) < 6;
            host_in_data = 5'($urandom);
            host_out_ready = $urandom_range(9) < 3;
            input_rdy_from_io = m_val ? ($urandom_range(2) == 0) : ($urandom_range(2) != 0);
            if (!output_rdy_from_io) output_data_from_io = 5'($urandom);
            output_rdy_from_io = m_ack ? ($urandom_range(2) == 0) : ($urandom_range(2) != 0);
            in_sz = in_q.size();
            out_sz = out_q.size();
            if (!m_val && input_rdy_from_io && in_sz > 0 && c - in_fall > GAP) begin
                m_val = 1;
                m_hold = in_q.pop_front();
            end else if (m_val && !input_rdy_from_io) begin
                m_val = 0; in_fall = c; m_ic++;
            end
            if (host_in_valid && in_sz < DEPTH) in_q.push_back(host_in_data);
            if (host_out_ready && out_sz > 0) void'(out_q.pop_front());
            if (!m_ack && output_rdy_from_io && out_sz < DEPTH && c - out_fall > GAP) begin
                m_ack = 1;
                out_q.push_back(output_data_from_io);
            end else if (m_ack && !output_rdy_from_io) begin
                m_ack = 0; out_fall = c; m_oc++;
            end
            @(negedge clk);
            head = out_q.size() > 0 ? out_q[0] : 5'd0;
            exp_v = {m_val, m_hold, m_ack, in_q.size() < DEPTH, out_q.size() > 0, head,
                     LW'(in_q.size()), LW'(out_q.size()), m_ic, m_oc};
            act_v = {input_val_to_io, input_data_to_io, output_ack_to_io, host_in_ready, host_out_valid, host_out_data,
                     in_level, out_level, in_chars, out_chars};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL random_cycle_%0d: got %h want %h", c, act_v, exp_v);
            end
        end
        host_in_valid = 0; host_out_ready = 0; input_rdy_from_io = 0; output_rdy_from_io = 0;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_gap();
        test_punch_backpressure();
        test_input_full();
        test_flush();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/io_tape_device.md
# io_tape_device

Device-side counterpart of the computer's I/O electronic unit. It acts as the tape reader on the input channel and the punch on the output channel. Host-side buffered 5-bit code streams are converted into the unit's four-phase rdy/val and rdy/ack handshakes. The block sits between the I/O unit's dev ports and a host stream source/sink (bench, UART bridge), with optional inter-character gap emulating mechanical speed.

## Interface
- DEPTH, 8: entries per FIFO; power of two, ≥2
- GAP, 4: minimum idle cycles between characters on each channel; 0 allowed
- clk  in  1  clock
- resetn  in  1  reset, asynchronous, active-low
- host_in_valid  in  1  host offers a code to be read by the computer
- host_in_ready  out  1  = !in_full
- host_in_data  in  5  code
- host_out_valid  out  1  = !out_empty
- host_out_ready  in  1  host accepts punched code
- host_out_data  out  5  out FIFO head; 5'b0 when empty
- flush  in  1  pulse, empties both FIFOs
- input_rdy_from_io  in  1  unit ready for a character (level)
- input_val_to_io  out  1  character valid (registered)
- input_data_to_io  out  5  character (registered hold reg)
- output_rdy_from_io  in  1  unit presents a character (level)
- output_ack_to_io  out  1  character taken (registered)
- output_data_from_io  in  5  character
- in_level, out_level  out  log2(DEPTH)+1  FIFO occupancy
- in_chars, out_chars  out  16  characters delivered / punched, wrap 16'hFFFF→0

## Operation
- Two independent circular FIFOs (in: host→unit, out: unit→host), pointer + count.
- Simultaneous push and pop: count unchanged. Push is blocked when full via ready. flush has priority and discards same-cycle pushes and pops.
- Reader FSM, input channel:
  - R_WAIT: val=0. When input_rdy && !in_empty && gap_in==0, pop head into hold reg → R_VAL.
  - R_VAL: val=1, data=hold. When input_rdy==0 → R_WAIT, gap_in←GAP, in_chars+1.
- Punch FSM, output channel:
  - P_WAIT: ack=0. When output_rdy && !out_full && gap_out==0, push output_data_from_io → P_ACK.
  - P_ACK: ack=1. When output_rdy==0 → P_WAIT, gap_out←GAP, out_chars+1.
  - A full out FIFO withholds ack (backpressure); the unit keeps rdy high and data stable.
- Gap counters decrement to 0 and saturate there.
- Hold reg keeps the last character after val falls and changes only on pop.
- flush does not affect the FSMs. A character already in the hold reg completes its handshake. A punch push in the flush cycle is lost, but ack still proceeds.
- val/ack never rise unless the corresponding rdy was sampled high, so the block never violates the unit's four-phase order.

## Timing
- Reset (async): FSMs in R_WAIT/P_WAIT, val=0, ack=0, hold=0, counts/pointers/gaps/char counters 0, host_in_ready=1, host_out_valid=0.
- Reset mid-handshake drops val/ack immediately.
- Input latency, with rdy high and gap 0:
  - push accepted at edge E0; pop at E1; val=1 after E1.
  - val falls 1 cycle after rdy is sampled low.
- Output latency: output_rdy sampled high in cycle c (space free, gap 0) → ack=1 and host_out_valid=1 after the edge ending c. ack falls 1 cycle after rdy is sampled low.
- Next character on a channel: val/ack rises no earlier than GAP+1 cycles after it fell, and only while rdy is high.
- host_in_ready, host_out_valid and host_out_data are combinational from FIFO state; host_out_data updates the cycle after a pop.

## Test plan
- Reset: drive resetn=0 mid-cycle during R_VAL → val=0 before next edge; in_level=0, host_in_ready=1, in_chars=0.
- Single read: push 5'b10011, rdy=1 → val=1 two cycles after push, data=10011; drop rdy → val=0 one cycle later, in_chars=1.
- Gap: GAP=4, push 10001 and 10010, unit re-raises rdy 3 cycles after val falls → second val rises exactly 5 cycles after the first fell, data 10010.
- Punch backpressure: DEPTH=8, host_out_ready=0, unit sends 0x10…0x18 → 8 acked, 9th rdy held with ack=0. Pop one → ack within 1 cycle. Host drains 0x10…0x18 in order; out_chars=9.
- Input full: push 9 codes with rdy=0 → host_in_ready=0 after 8, in_level=8, 9th not accepted.
- Flush during R_VAL holding 10101 with 3 queued → in_level=0 next cycle, val stays 1 with 10101 until rdy falls, then in_chars+1.
